// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC cosine coprocessor.
// Optional sine output is enabled with CORDIC_SINE_OUT_EN.
package cordic_pkg;

  localparam int FIX_W  = 32;
  localparam int FRAC_W = 30;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;

  // CORDIC gain compensation, 0.6072529350 in Q2.30
  localparam logic signed [FIX_W-1:0] K = 32'sh26DD3B6A;

  // round(atan(2^-i) * 2^30)
  localparam logic [FIX_W-1:0] ATAN [30] = '{
    32'h3243F6A9, 32'h1DAC6705, 32'h0FADBAFD, 32'h07F56EA7,
    32'h03FEAB77, 32'h01FFD55C, 32'h00FFFAAB, 32'h007FFF55,
    32'h003FFFEB, 32'h001FFFFD, 32'h00100000, 32'h00080000,
    32'h00040000, 32'h00020000, 32'h00010000, 32'h00008000,
    32'h00004000, 32'h00002000, 32'h00001000, 32'h00000800,
    32'h00000400, 32'h00000200, 32'h00000100, 32'h00000080,
    32'h00000040, 32'h00000020, 32'h00000010, 32'h00000008,
    32'h00000004, 32'h00000002
  };

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    ITER,
    PACK
  } state_e;

endpackage

// File: rtl/cordic_fix_to_float.sv
// Q2.30 fixed-point to IEEE-754 single: leading-one detect and pack.
// Used for cosine, and for sine when CORDIC_SINE_OUT_EN is defined.
module cordic_fix_to_float
  import cordic_pkg::*;
#(
  parameter bit SIGNED_IN = 1'b0
) (
  input  logic signed [FIX_W-1:0] fix_i,
  output logic [31:0]             flt_o
);

  logic                 sgn;
  logic [FIX_W-2:0]     mag;
  logic [4:0]           lead;
  logic [EXP_W-1:0]     exp_f;
  logic [MANT_W-1:0]    man_f;
  logic                 is_zero;

  // Split sign/magnitude, find leading one, truncate the mantissa
  always_comb begin
    sgn     = 1'b0;
    mag     = fix_i[FIX_W-2:0];
    lead    = '0;
    is_zero = 1'b0;
    if (SIGNED_IN) begin
      is_zero = (fix_i == '0);
      if (fix_i[FIX_W-1]) begin
        sgn = 1'b1;
        mag = 31'(-fix_i);
      end
    end else begin
      is_zero = (fix_i <= 0);
    end
    for (int i = 0; i < FIX_W - 1; i++) begin
      if (mag[i]) lead = 5'(i);
    end
    exp_f = 8'(lead) + 8'(BIAS - FRAC_W);
    man_f = 23'({mag, 23'b0} >> lead);
    flt_o = is_zero ? 32'h0 : {sgn, exp_f, man_f};
  end

endmodule

// File: rtl/cordic_cosine.sv
// Start/done CORDIC coprocessor computing cos(angle) on IEEE-754 singles.
// Define CORDIC_SINE_OUT_EN to add the sine output port.
module cordic_cosine
  import cordic_pkg::*;
#(
  parameter int ITERATIONS = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] angle,
  output logic        done,
  output logic        busy,
`ifdef CORDIC_SINE_OUT_EN
  output logic [31:0] sine,
`endif
  output logic [31:0] result
);

  state_e                  state_q;
  logic [4:0]              cnt_q;
  logic [30:0]             ang_q;
  logic signed [FIX_W-1:0] x_q, y_q, z_q;
  logic signed [FIX_W-1:0] x_d, y_d, z_d;
  logic [31:0]             result_q;
  logic                    done_q;
  logic                    busy_q;

  logic [EXP_W-1:0]        a_exp;
  logic [MANT_W-1:0]       a_man;
  logic [30:0]             z0;
  logic [31:0]             cos_f;

  assign a_exp = ang_q[30:23];
  assign a_man = ang_q[22:0];

  // Float magnitude to Q2.30; cosine is even, so the rotation
  // always runs on |angle| and +a / -a give bit-identical results
  always_comb begin
    z0 = '0;
    if (a_exp >= 8'd127) begin
      z0 = 31'h40000000;
    end else if (a_exp >= 8'd97) begin
      z0 = {1'b1, a_man, 7'b0} >> (8'd127 - a_exp);
    end
  end

  // One CORDIC micro-rotation at step cnt_q
  always_comb begin
    logic signed [FIX_W-1:0] sx, sy, at;
    sx  = x_q >>> cnt_q;
    sy  = y_q >>> cnt_q;
    at  = signed'(ATAN[cnt_q]);
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    if (!z_q[FIX_W-1]) begin
      x_d = x_q - sy;
      y_d = y_q + sx;
      z_d = z_q - at;
    end else begin
      x_d = x_q + sy;
      y_d = y_q - sx;
      z_d = z_q + at;
    end
  end

  cordic_fix_to_float #(
    .SIGNED_IN(1'b0)
  ) u_cos (
    .fix_i(x_q),
    .flt_o(cos_f)
  );

`ifdef CORDIC_SINE_OUT_EN
  logic                    sgn_q;
  logic [31:0]             sine_q;
  logic [31:0]             sin_f;
  logic signed [FIX_W-1:0] y_fin;

  assign y_fin = sgn_q ? -y_q : y_q;

  cordic_fix_to_float #(
    .SIGNED_IN(1'b1)
  ) u_sin (
    .fix_i(y_fin),
    .flt_o(sin_f)
  );

  assign sine = sine_q;
`endif

  // Control FSM with datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ang_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef CORDIC_SINE_OUT_EN
      sgn_q    <= 1'b0;
      sine_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            ang_q   <= angle[30:0];
            busy_q  <= 1'b1;
            state_q <= CONV;
`ifdef CORDIC_SINE_OUT_EN
            sgn_q   <= angle[31];
`endif
          end
        end
        CONV: begin
          x_q     <= K;
          y_q     <= '0;
          z_q     <= {1'b0, z0};
          cnt_q   <= '0;
          state_q <= ITER;
        end
        ITER: begin
          x_q   <= x_d;
          y_q   <= y_d;
          z_q   <= z_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(ITERATIONS - 1)) state_q <= PACK;
        end
        PACK: begin
          result_q <= cos_f;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
`ifdef CORDIC_SINE_OUT_EN
          sine_q   <= sin_f;
`endif
        end
      endcase
    end
  end

  assign done   = done_q;
  assign busy   = busy_q;
  assign result = result_q;

endmodule

// File: tb/tb_cordic_cosine.sv
// Randomised bench for cordic_cosine against a real-arithmetic model.
// Also checks sine when CORDIC_SINE_OUT_EN is defined.
module tb_cordic_cosine;

  localparam int  N   = 24;
  localparam real TOL = 1.0 / 1048576.0;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] angle;
  logic        done;
  logic        busy;
  logic [31:0] result;
`ifdef CORDIC_SINE_OUT_EN
  logic [31:0] sine;
`endif

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cordic_cosine #(.ITERATIONS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .angle (angle),
    .done  (done),
    .busy  (busy),
`ifdef CORDIC_SINE_OUT_EN
    .sine  (sine),
`endif
    .result(result)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // IEEE single to real; inf/NaN map to magnitude 2 (saturates anyway)
  function automatic real f2r(input logic [31:0] b);
    int  e;
    real v;
    e = int'(b[30:23]);
    if (e == 0) v = 0.0;
    else if (e == 255) v = 2.0;
    else v = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** real'(e - 127));
    return b[31] ? -v : v;
  endfunction

  function automatic real clamp1(input real v);
    if (v > 1.0) return 1.0;
    if (v < -1.0) return -1.0;
    return v;
  endfunction

  task automatic acc(input string tag, input logic [31:0] a,
                     input logic [31:0] r);
    real d;
    d = f2r(r) - $cos(clamp1(f2r(a)));
    chk($sformatf("%s_cos a=%h r=%h", tag, a, r),
        {31'b0, (d <= TOL && d >= -TOL)}, 32'd1);
`ifdef CORDIC_SINE_OUT_EN
    d = f2r(sine) - $sin(clamp1(f2r(a)));
    chk($sformatf("%s_sin a=%h s=%h", tag, a, sine),
        {31'b0, (d <= TOL && d >= -TOL)}, 32'd1);
`endif
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  // poke>0 raises a stray start in that cycle of the operation.
  task automatic run(input logic [31:0] a, input int poke,
                     output logic [31:0] r, output int lat);
    start = 1'b1;
    angle = a;
    @(negedge clk);
    start = 1'b0;
    angle = $urandom;
    lat   = 1;
    while (!done && lat < 100) begin
      start = (lat == poke);
      if (lat == poke) angle = 32'h3F000000;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    r = result;
  endtask

  logic [31:0] r1, r, rz;
  int          lat;
  bit          seen;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    angle = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run(32'h3F800000, 0, r1, lat);
    chk("lat_one", lat, N + 3);
    acc("one", 32'h3F800000, r1);
    @(negedge clk);
    chk("done_pulse", {31'b0, done}, 32'd0);
    chk("hold", result, r1);
    chk("idle_busy", {31'b0, busy}, 32'd0);

    run(32'hBF800000, 0, r, lat);
    chk("neg_one", r, r1);
    run(32'h40000000, 0, r, lat);
    chk("b2b_lat", lat, N + 3);
    chk("sat_two", r, r1);
    run(32'h7FC00000, 0, r, lat);
    chk("sat_nan", r, r1);
    run(32'hFF800000, 0, r, lat);
    chk("sat_ninf", r, r1);

    run(32'h00000000, 0, rz, lat);
    acc("zero", 32'h00000000, rz);
    run(32'h30800000, 0, r, lat);
    chk("tiny_eq", r, rz);
    run(32'h33800000, 0, r, lat);
    acc("small", 32'h33800000, r);
    run(32'h3F000000, 0, r, lat);
    acc("half", 32'h3F000000, r);

    @(negedge clk);
    run(32'h3F800000, 5, r, lat);
    chk("busy_lat", lat, N + 3);
    chk("busy_ign", r, r1);

    @(negedge clk);
    start = 1'b1;
    angle = 32'h3F000000;
    @(negedge clk);
    start = 1'b0;
    chk("op_busy", {31'b0, busy}, 32'd1);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_result", result, 32'h0);
    chk("mid_busy", {31'b0, busy}, 32'd0);
    seen = done;
    repeat (N + 6) begin
      @(negedge clk);
      seen = seen | done;
    end
    chk("mid_nodone", {31'b0, seen}, 32'd0);
    run(32'h3F800000, 0, r, lat);
    chk("after_lat", lat, N + 3);
    chk("after_rst", r, r1);

    for (int k = 0; k < 30; k++) begin
      logic [31:0] a, rn;
      int e;
      if (k % 6 == 5) e = $urandom_range(255, 127);
      else e = $urandom_range(126, 96);
      a = {1'($urandom), 8'(e), 23'($urandom)};
      run(a, 0, r, lat);
      chk($sformatf("rnd_lat a=%h", a), lat, N + 3);
      acc("rnd", a, r);
      run(a ^ 32'h80000000, 0, rn, lat);
      chk($sformatf("rnd_sym a=%h", a), rn, r);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
